boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Byte-serial instruction loader sitting directly upstream of the processor top; it feeds the instruction memory's write port.
- It receives a framed program image one byte per handshake, packs the bytes into WIDTH-bit words, and writes them sequentially into instruction memory from address 0.
- It holds the processor in reset until the image is loaded and verified.

Parameters:
- WIDTH, 32, data/address width; must be 32 (4 bytes per word).
- SIZE, 102, instruction memory depth in words; upper bound on the frame word count.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_valid  input  1  rx_data holds a valid byte
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction memory write strobe, one cycle
- imem_addr  output  WIDTH  byte address of the write, always word-aligned (word_index << 2)
- imem_wdata  output  WIDTH  word to write
- cpu_reset  output  1  processor reset; high until load completes
- done  output  1  image loaded and verified
- error  output  1  frame rejected

Behaviour:
- Reset values: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, state=IDLE.
- Byte transfer: a byte is accepted on a rising clk when rx_valid && rx_ready. rx_ready=1 in IDLE, CNT_HI, CNT_LO, DATA and CSUM; rx_ready=0 in DONE and ERROR.
- Frame format: SYNC_BYTE, count[15:8], count[7:0], count*4 payload bytes (little-endian per word), then one checksum byte equal to the XOR of all payload bytes.
- State IDLE: a byte equal to SYNC_BYTE -> CNT_HI; any other byte is discarded and the state stays IDLE.
- State CNT_HI: latch count[15:8] -> CNT_LO.
- State CNT_LO: latch count[7:0], then check the full count:
  - count > SIZE -> ERROR.
  - count == 0 -> CSUM.
  - otherwise -> DATA.
- State DATA: the byte lane counter (0..3) selects the word byte: lane 0 -> [7:0] ... lane 3 -> [31:24].
  - On acceptance of lane 3, the registered outputs on the next edge are imem_we=1, imem_wdata=packed word, imem_addr=word_index<<2. Write latency is 1 cycle after the 4th byte.
  - word_index then increments; lane wraps to 0.
  - After the write of word count-1 -> CSUM.
- Checksum: the running XOR is cleared on entry to CNT_HI and updated on every accepted payload byte.
- State CSUM: accepted byte == running XOR -> DONE, else -> ERROR.
- State DONE: done=1, cpu_reset=0 (both registered on the edge that enters DONE). The state is held until reset; further rx_valid is ignored.
- State ERROR: error=1, cpu_reset stays 1. Held until reset.
- imem_we is never asserted outside DATA-lane-3 acceptance. imem_addr and imem_wdata hold their last values when imem_we=0.
- Second SYNC_BYTE mid-frame: treated as ordinary data or count, with no resync.
- Reset mid-frame: the state machine returns to IDLE immediately (asynchronously) and any partial word is dropped. Words already written stay in memory, and cpu_reset returns to 1.
- rx_valid low between bytes: the block waits indefinitely in the current state; there is no timeout.

Optional Feature:
- Macro name: BOOT_LOADER_CSUM_EN.
- With the macro defined: CSUM state and checksum byte exactly as specified above.
- Without the macro: no checksum byte is expected and the XOR logic is absent.
  - After the last payload word is written, the state goes directly to DONE.
  - count == 0 goes from CNT_LO straight to DONE.

Decomposition:
- Package boot_pkg:
  - state enum boot_state_t {IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERROR}
  - SYNC_BYTE default constant
  - BYTES_PER_WORD=4
- Sub-module boot_word_packer: byte lane counter plus shift/assemble register. Inputs: clk, reset, clear, byte_en, byte. Outputs: word, word_valid pulse. Emits one word per 4 accepted bytes.
- The top-level FSM, counters and checksum live in boot_loader.

Test Plan:
- Frame A5,00,02, bytes 11 22 33 44 55 66 77 88, checksum 88 -> writes: addr 0x0 = 0x44332211, addr 0x4 = 0x88776655; then done=1, cpu_reset=0, error=0.
- Same frame with checksum 00 -> error=1, cpu_reset=1, done=0. Both words are still written, and rx_ready=0 afterward.
- Leading garbage 00 FF 5A, then a valid 1-word frame -> garbage produces no writes; the word lands at addr 0x0 and done=1.
- Count 0x0067 (103 > SIZE) -> error=1 immediately after the CNT_LO byte, with no imem_we pulses.
- Assert reset after 6 payload bytes, then send a full valid 1-word frame -> the first write lands at addr 0x0 and done=1.
- With BOOT_LOADER_CSUM_EN undefined: A5,00,01, DE AD BE EF -> one write of 0xEFBEADDE at addr 0x0, then done=1 with no checksum byte consumed.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the byte-serial boot loader.
// Checksum stage is built in only with BOOT_LOADER_CSUM_EN defined.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } boot_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian bytes into words; word_valid marks the 4th byte.
// word/word_valid are combinational so the caller can register the write.
module boot_word_packer
  import boot_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       rx_byte,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  localparam int LW = $clog2(BYTES_PER_WORD);
  localparam logic [LW-1:0] LAST = LW'(BYTES_PER_WORD - 1);

  logic [LW-1:0]    lane;
  logic [WIDTH-9:0] acc;

  assign word_valid = byte_en && (lane == LAST);
  // Earlier bytes shift down so lane 0 ends up in [7:0].
  assign word = {rx_byte, acc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
      acc  <= '0;
    end else if (clear) begin
      lane <= '0;
      acc  <= '0;
    end else if (byte_en) begin
      lane <= lane + 1'b1;
      acc  <= {rx_byte, acc[WIDTH-9:8]};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Framed byte-serial image loader into instruction memory.
// Optional macro BOOT_LOADER_CSUM_EN adds the trailing XOR checksum byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         SIZE      = 102,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error
);

  boot_state_t      state;
  logic [7:0]       cnt_hi;
  logic [15:0]      count;
  logic [15:0]      word_idx;
  logic [15:0]      cnt_full;
  logic             accept;
  logic             word_valid;
  logic [WIDTH-1:0] word;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  assign accept   = rx_valid && rx_ready;
  assign cnt_full = {cnt_hi, rx_data};

  boot_word_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != DATA),
    .byte_en    (accept && (state == DATA)),
    .rx_byte    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt_hi     <= '0;
      count      <= '0;
      word_idx   <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= CNT_HI;
`ifdef BOOT_LOADER_CSUM_EN
              csum  <= '0;
`endif
            end
          end
          CNT_HI: begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
          CNT_LO: begin
            count    <= cnt_full;
            word_idx <= '0;
            if (cnt_full > 16'(SIZE)) begin
              state    <= ERROR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (cnt_full == 16'd0) begin
`ifdef BOOT_LOADER_CSUM_EN
              state     <= CSUM;
`else
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
              rx_ready  <= 1'b0;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
`ifdef BOOT_LOADER_CSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (word_valid) begin
              imem_we    <= 1'b1;
              imem_wdata <= word;
              imem_addr  <= WIDTH'({word_idx, 2'b00});
              word_idx   <= word_idx + 16'd1;
              if (word_idx == count - 16'd1) begin
`ifdef BOOT_LOADER_CSUM_EN
                state     <= CSUM;
`else
                state     <= DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
                rx_ready  <= 1'b0;
`endif
              end
            end
          end
`ifdef BOOT_LOADER_CSUM_EN
          CSUM: begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
// Checksum bytes are sent only when BOOT_LOADER_CSUM_EN is defined.
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [31:0] waddr[$];
  logic [31:0] wdata[$];

  boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      waddr.push_back(imem_addr);
      wdata.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    waddr.delete();
    wdata.delete();
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two-word frame
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
`ifdef BOOT_LOADER_CSUM_EN
    send(8'h88);
`endif
    settle();
    chk("t1_nwr", waddr.size(), 32'd2);
    chk("t1_addr0", waddr[0], 32'h0);
    chk("t1_data0", wdata[0], 32'h44332211);
    chk("t1_addr1", waddr[1], 32'h4);
    chk("t1_data1", wdata[1], 32'h88776655);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_rx_ready", 32'(rx_ready), 32'd0);
    // Bytes after DONE are ignored
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    settle();
    chk("t1_ign_nwr", waddr.size(), 32'd2);
    chk("t1_ign_done", 32'(done), 32'd1);

`ifdef BOOT_LOADER_CSUM_EN
    // Bad checksum
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(8'h00);
    settle();
    chk("t2_nwr", waddr.size(), 32'd2);
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_done", 32'(done), 32'd0);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_rx_ready", 32'(rx_ready), 32'd0);
`endif

    // Leading garbage, then one word with an rx_valid gap
    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    settle();
    chk("t3_garbage_nwr", waddr.size(), 32'd0);
    chk("t3_garbage_ready", 32'(rx_ready), 32'd1);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hDE);
    repeat (3) @(posedge clk);
    #1;
    send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef BOOT_LOADER_CSUM_EN
    send(8'h22);
`endif
    settle();
    chk("t3_nwr", waddr.size(), 32'd1);
    chk("t3_addr", waddr[0], 32'h0);
    chk("t3_data", wdata[0], 32'hEFBEADDE);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_error", 32'(error), 32'd0);

    // Count 103 exceeds SIZE
    do_reset();
    send(8'hA5); send(8'h00); send(8'h67);
    chk("t4_error", 32'(error), 32'd1);
    settle();
    chk("t4_nwr", waddr.size(), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t4_rx_ready", 32'(rx_ready), 32'd0);

    // Count 102 is accepted
    do_reset();
    send(8'hA5); send(8'h00); send(8'h66);
    chk("t4b_error", 32'(error), 32'd0);
    chk("t4b_rx_ready", 32'(rx_ready), 32'd1);

    // High count byte counts: 0x0100
    do_reset();
    send(8'hA5); send(8'h01); send(8'h00);
    chk("t4c_error", 32'(error), 32'd1);

    // Empty image
    do_reset();
    send(8'hA5); send(8'h00); send(8'h00);
`ifdef BOOT_LOADER_CSUM_EN
    send(8'h00);
`endif
    settle();
    chk("t4d_done", 32'(done), 32'd1);
    chk("t4d_nwr", waddr.size(), 32'd0);

    // Reset mid-frame after 6 payload bytes
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66);
    settle();
    chk("t5_pre_nwr", waddr.size(), 32'd1);
    reset = 1'b1;
    #2;
    chk("t5_rst_ready", 32'(rx_ready), 32'd1);
    chk("t5_rst_cpu", 32'(cpu_reset), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    waddr.delete();
    wdata.delete();
    // Mid-frame sync byte is plain data
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hA5); send(8'h02); send(8'h03); send(8'h04);
`ifdef BOOT_LOADER_CSUM_EN
    send(8'hA0);
`endif
    settle();
    chk("t5_nwr", waddr.size(), 32'd1);
    chk("t5_addr", waddr[0], 32'h0);
    chk("t5_data", wdata[0], 32'h040302A5);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
